// File: rtl/ide_pkg.sv
// Shared types for the IDE device-side reset sequencer.
package ide_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_CPU = 2'd2,
      SIG      = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_HW   = 2'd1,
      CAUSE_SRST = 2'd2,
      CAUSE_CPU  = 2'd3
   } cause_t;

endpackage

// File: rtl/ide_reset_controller_if.sv
// Reset-source inputs and taskfile/CPU-facing outputs of the reset sequencer.
interface ide_reset_controller_if;
   import ide_pkg::*;

   logic   hw_rst;
   logic   srst;
   logic   cpu_rst_req;
   logic   cpu_done;
   logic   cpu_irq_ack;
   logic   dev_rst;
   logic   bsy;
   logic   sig_load;
   logic   cpu_irq;
   cause_t rst_cause;
   logic   timeout;

   // Side that sources the reset requests (bus filter, DevCtl, firmware).
   modport master (
      output hw_rst, srst, cpu_rst_req, cpu_done, cpu_irq_ack,
      input  dev_rst, bsy, sig_load, cpu_irq, rst_cause, timeout
   );

   // The reset controller itself.
   modport slave (
      input  hw_rst, srst, cpu_rst_req, cpu_done, cpu_irq_ack,
      output dev_rst, bsy, sig_load, cpu_irq, rst_cause, timeout
   );

endinterface

// File: rtl/ide_reset_controller.sv
// Device-side reset sequencer: hold taskfile in reset, hand off to firmware,
// then load the reset signature and release BSY. One counter serves both the
// minimum hold time and the firmware timeout.
module ide_reset_controller
   import ide_pkg::*;
#(
   parameter int HOLD_CYCLES    = 64,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 21
) (
   input  logic                    clk,
   input  logic                    rst,
   ide_reset_controller_if.slave   bus
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_n;
   cause_t           act_cause, act_cause_n;   // source that owns the current ASSERT
   cause_t           rst_cause_q, rst_cause_n; // reported cause, latched at handoff
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             srst_q;
   logic             srst_edge;
   logic             irq_set, to_set;
   logic             dev_rst_q, bsy_q, sig_load_q, cpu_irq_q, timeout_q;

   assign srst_edge = bus.srst & ~srst_q;

   // Next-state: hw_rst level beats an SRST edge, which beats a firmware request.
   always_comb begin
      state_n     = state;
      act_cause_n = act_cause;
      rst_cause_n = rst_cause_q;
      cnt_n       = cnt;
      irq_set     = 1'b0;
      to_set      = 1'b0;
      if (bus.hw_rst) begin
         // Held in ASSERT with the hold counter pinned at zero while hw_rst is high.
         state_n     = ASSERT;
         act_cause_n = CAUSE_HW;
         cnt_n       = '0;
      end else if (srst_edge && state != ASSERT) begin
         state_n     = ASSERT;
         act_cause_n = CAUSE_SRST;
         cnt_n       = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cpu_rst_req) begin
                  state_n     = ASSERT;
                  act_cause_n = CAUSE_CPU;
                  cnt_n       = '0;
               end
            end
            ASSERT: begin
               if (cnt != HOLD_MAX) begin
                  cnt_n = cnt + CNT_ONE;
               end else if (act_cause != CAUSE_SRST || !bus.srst) begin
                  // Hold satisfied and source released: hand off to firmware.
                  state_n     = WAIT_CPU;
                  cnt_n       = '0;
                  rst_cause_n = act_cause;
                  irq_set     = 1'b1;
               end
            end
            WAIT_CPU: begin
               if (bus.cpu_done) begin
                  state_n = SIG;
               end else if (cnt == TO_LAST) begin
                  state_n = SIG;
                  to_set  = 1'b1;
               end else begin
                  cnt_n = cnt + CNT_ONE;
               end
            end
            SIG:     state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // State, counter and registered outputs; outputs follow the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ASSERT;
         act_cause   <= CAUSE_HW;
         rst_cause_q <= CAUSE_HW;
         cnt         <= '0;
         srst_q      <= 1'b0;
         dev_rst_q   <= 1'b1;
         bsy_q       <= 1'b1;
         sig_load_q  <= 1'b0;
         cpu_irq_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state       <= state_n;
         act_cause   <= act_cause_n;
         rst_cause_q <= rst_cause_n;
         cnt         <= cnt_n;
         srst_q      <= bus.srst;
         dev_rst_q   <= (state_n == ASSERT);
         bsy_q       <= (state_n != IDLE);
         sig_load_q  <= (state_n == SIG);
         // A set in the same cycle as the ack takes priority.
         if (irq_set)              cpu_irq_q <= 1'b1;
         else if (bus.cpu_irq_ack) cpu_irq_q <= 1'b0;
         if (to_set)               timeout_q <= 1'b1;
         else if (bus.cpu_irq_ack) timeout_q <= 1'b0;
      end
   end

   assign bus.dev_rst   = dev_rst_q;
   assign bus.bsy       = bsy_q;
   assign bus.sig_load  = sig_load_q;
   assign bus.cpu_irq   = cpu_irq_q;
   assign bus.rst_cause = rst_cause_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: doc/ide_reset_controller.md
# ide_reset_controller

Sequences device-side reset of the IDE/ATA target in response to three reset sources: filtered bus hardware reset, the host SRST bit, and firmware-requested reset. Holds the taskfile in reset with BSY set, hands off to the embedded CPU for re-initialisation, then triggers the reset-signature load and releases BSY. Sits between the bus reset filter, the Device Control register and the taskfile/status logic.

## Interface
- HOLD_CYCLES, 64: minimum cycles count held in ASSERT before release (≥1).
- TIMEOUT_CYCLES, 1000000: maximum cycles waited for firmware in WAIT_CPU (≥2).
- CNT_W, 21: counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- hw_rst  in  1  filtered bus reset, active-high, synchronous to clk.
- srst  in  1  SRST bit of Device Control register (level).
- cpu_rst_req  in  1  one-cycle firmware reset request.
- cpu_done  in  1  one-cycle pulse: firmware finished re-initialisation.
- cpu_irq_ack  in  1  clears cpu_irq and timeout.
- dev_rst  out  1  reset to taskfile/ATA register logic.
- bsy  out  1  forces BSY in status register.
- sig_load  out  1  one-cycle pulse: load reset signature into taskfile.
- cpu_irq  out  1  level interrupt to CPU: reset handoff pending.
- rst_cause  out  2  0 none, 1 hw, 2 srst, 3 cpu.
- timeout  out  1  sticky: last handoff ended by timeout.

## Operation
- States: IDLE, ASSERT, WAIT_CPU, SIG. All outputs registered.
- Async rst: state ASSERT, cause hw(1), cnt 0, dev_rst 1, bsy 1, sig_load 0, cpu_irq 0, timeout 0, srst_q 0.
- Triggers, priority hw > srst > cpu: hw_rst=1 (level); srst rising edge (srst & ~srst_q); cpu_rst_req=1.
- hw_rst from any state -> ASSERT, cause 1. srst edge from IDLE/WAIT_CPU/SIG -> ASSERT, cause 2. cpu_rst_req only in IDLE -> ASSERT, cause 3; ignored elsewhere.
- ASSERT entry (including re-entry from ASSERT by hw_rst, or by srst edge): cnt=0. Each cycle cnt increments, saturating at HOLD_CYCLES. dev_rst=1, bsy=1.
- ASSERT -> WAIT_CPU when cnt==HOLD_CYCLES and active source released (cause 1: hw_rst=0; cause 2: srst=0; cause 3: none). Same edge: cnt=0, dev_rst=0, cpu_irq=1, rst_cause latched.
- WAIT_CPU: bsy=1; cnt increments. cpu_done -> SIG. cnt==TIMEOUT_CYCLES-1 without cpu_done -> SIG, timeout=1.
- SIG: one cycle, sig_load=1, bsy=1; -> IDLE; bsy=0 in IDLE.
- cpu_irq_ack clears cpu_irq and timeout; a same-cycle set wins over ack.
- rst_cause holds until next ASSERT->WAIT_CPU transition.

## Timing
- Trigger sampled at edge N: dev_rst/bsy high from edge N+... i.e. visible after edge N (already high if bsy set).
- Min dev_rst pulse: HOLD_CYCLES+1 cycles after entry.
- cpu_done at edge M: sig_load high for cycle after M; bsy low one cycle later.
- Timeout path: WAIT_CPU lasts exactly TIMEOUT_CYCLES cycles.
- Boundary: hw_rst and cpu_done same cycle -> ASSERT, no sig_load. srst held high through WAIT_CPU without new edge -> no restart. srst rising while hw_rst=1 -> cause stays 1. rst mid-sequence -> reset values immediately.

## Structure
- Shared package ide_pkg: state enum (IDLE, ASSERT, WAIT_CPU, SIG), rst_cause encodings (CAUSE_NONE/HW/SRST/CPU).
- Single module; one shared CNT_W counter for hold and timeout; no sub-module.

## Test plan
- HOLD=8, TIMEOUT=32. Release rst with hw_rst=0 -> dev_rst high 9 cycles, cpu_irq=1, rst_cause=1; cpu_done after 5 cycles -> sig_load 1-cycle pulse, bsy low next cycle.
- srst high 20 cycles from IDLE -> dev_rst held until srst low (≥9 cycles), rst_cause=2, full handoff with cpu_done.
- cpu_rst_req in IDLE, no cpu_done -> WAIT_CPU 32 cycles, timeout=1, sig_load pulse; cpu_irq_ack -> cpu_irq=0, timeout=0.
- hw_rst asserted in WAIT_CPU coincident with cpu_done -> ASSERT, no sig_load, cnt restarts, rst_cause=1 after release.
- cpu_rst_req during WAIT_CPU ignored; srst rising during WAIT_CPU restarts ASSERT with cause 2.
- Async rst mid-ASSERT and mid-SIG -> all outputs to reset values without clock edge.
